inst_fetch_queue: RTL
=====================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries, power of two, 2..8.
REQ-002 SHALL have parameter ADDR_W, default 4: instruction-memory address width (16 words).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port imem_addr, output, ADDR_W: read address to instruction memory, equal to the fetch PC.
REQ-006 SHALL have port imem_rd, output, 1: read strobe. Memory samples imem_addr on the edge where imem_rd=1. imem_rdata is valid in the following cycle.
REQ-007 SHALL have port imem_rdata, input, 32: instruction word returned by memory.
REQ-008 SHALL have port redirect, input, 1: one-cycle branch/jump request from execute.
REQ-009 SHALL have port redirect_pc, input, ADDR_W: redirect target.
REQ-010 SHALL have port halt, input, 1: level; while 1, no new reads are issued.
REQ-011 SHALL have port ir, output, 32: instruction at queue head.
REQ-012 SHALL have port ir_pc, output, ADDR_W: address of the ir word.
REQ-013 SHALL have port ir_valid, output, 1: head entry present.
REQ-014 SHALL have port ir_ready, input, 1: consumer accepts the head.
REQ-015 SHALL have port fq_count, output, clog2(DEPTH)+1: occupied entries.

Function
REQ-016 SHALL hold fetch PC; imem_addr = PC.
- imem_rd = !halt && !redirect && (fq_count + inflight < DEPTH), combinational.
REQ-017 SHALL increment PC by 1 mod 2^ADDR_W on each issued read; 15 wraps to 0.
REQ-018 SHALL set inflight=1 for the cycle after an issued read, then push {imem_rdata, issued PC} at that cycle's closing edge unless squashed.
REQ-019 SHALL pop the head on any edge where ir_valid && ir_ready; ir/ir_pc/ir_valid are driven from queue head (no added latency).
REQ-020 SHALL allow simultaneous push and pop; fq_count unchanged, ordering preserved.
REQ-021 SHALL never push when full; reservation (REQ-016) guarantees it; overflow is a design error (assert in simulation).
REQ-022 SHALL on redirect=1:
- empty the queue and squash any inflight response at that edge;
- load PC <= redirect_pc;
- ir_valid=0 in the next cycle;
- redirect beats push and pop in the same cycle (a same-cycle pop is not counted as consumed).
REQ-023 SHALL on the cycle after redirect issue a read at redirect_pc if halt=0.
REQ-024 SHALL complete an inflight read when halt rises (entry pushed); queued entries continue to drain.
REQ-025 SHALL give latency: read issued at edge N -> entry visible (ir_valid=1) after edge N+1.
REQ-026 SHALL keep ir and ir_pc stable while ir_valid && !ir_ready.

Reset
REQ-027 SHALL, on sys_rst=0, asynchronously clear:
- PC=0, queue pointers=0, fq_count=0, inflight=0;
- ir_valid=0, ir=0, ir_pc=0.
REQ-028 SHALL discard all queued and inflight data on reset asserted mid-operation; first read after release is address 0.
REQ-029 SHALL drive imem_rd=0 while sys_rst=0.

Configuration
REQ-030 SHALL, with FETCH_PERF_EN defined, add two outputs and their counters:
- fetch_cnt (16 bits): increments per pushed entry.
- stall_cnt (16 bits): increments per cycle with ir_valid && !ir_ready.
- Both saturate at 0xFFFF and reset to 0.
REQ-031 SHALL, without FETCH_PERF_EN, omit the ports and counters; all other behaviour identical.

Verification
REQ-032 SHALL cover streaming:
- Stimulus: reset release, ir_ready=1, memory word k = 0xA000_0000+k.
- Required: ir_valid first 1 two edges after release; ir_pc 0,1,2,... one per cycle; pc 15 followed by 0.
REQ-033 SHALL cover backpressure:
- Stimulus: ir_ready=0 for 10 cycles.
- Required: fq_count reaches 4, imem_rd=0, ir holds 0xA000_0000.
- Then: ir_ready=1 yields pcs 0..3 back-to-back with no gap.
REQ-034 SHALL cover redirect:
- Stimulus: redirect=1, redirect_pc=9 while 3 queued and 1 inflight.
- Required: next cycle ir_valid=0, fq_count=0; first entry after is ir_pc=9; no entries from pcs 3..5 appear.
REQ-035 SHALL cover halt:
- Stimulus: halt=1 with 1 inflight and 2 queued.
- Required: 3 entries delivered, then ir_valid=0 and imem_rd=0 until halt=0; fetch resumes at the next PC.
REQ-036 SHALL cover reset mid-stream:
- Stimulus: sys_rst=0 asynchronously between edges.
- Required: ir_valid=0 immediately; after release, ir_pc=0 first.
- With FETCH_PERF_EN: fetch_cnt=0.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential reads, buffers returned words, supports redirect/halt.
// Optional build macro FETCH_PERF_EN adds fetch_cnt/stall_cnt performance counters.
module inst_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     sys_rst,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic                     imem_rd,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     halt,
  output logic [31:0]              ir,
  output logic [ADDR_W-1:0]        ir_pc,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  output logic [$clog2(DEPTH):0]   fq_count
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]              fetch_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] infl_pc;
  logic              inflight;
  logic [31:0]       q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       reserved;
  logic              issue;
  logic              push;
  logic              pop;

  // Issue only when every queued entry plus the pending response still leaves a free slot.
  always_comb begin
    reserved = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue    = sys_rst && !halt && !redirect && (reserved < (CW+1)'(DEPTH));
    push     = inflight && !redirect;
    pop      = ir_valid && ir_ready && !redirect;
  end

  assign imem_addr = pc;
  assign imem_rd   = issue;
  assign ir        = q_data[rd_ptr];
  assign ir_pc     = q_pc[rd_ptr];
  assign ir_valid  = (count != {CW{1'b0}});
  assign fq_count  = count;

  // Fetch PC, inflight tracking, queue pointers and occupancy; redirect overrides push and pop.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pc       <= {ADDR_W{1'b0}};
      infl_pc  <= {ADDR_W{1'b0}};
      inflight <= 1'b0;
      rd_ptr   <= {PW{1'b0}};
      wr_ptr   <= {PW{1'b0}};
      count    <= {CW{1'b0}};
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= {PW{1'b0}};
      wr_ptr   <= {PW{1'b0}};
      count    <= {CW{1'b0}};
    end else begin
      if (issue) begin
        pc      <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        infl_pc <= pc;
      end
      inflight <= issue;
      if (push) wr_ptr <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, 1'b1};
      case ({push, pop})
        2'b10:   count <= count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count <= count - {{(CW-1){1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so ir/ir_pc read as zero afterwards.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= 32'd0;
        q_pc[i]   <= {ADDR_W{1'b0}};
      end
    end else if (push) begin
      q_data[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= infl_pc;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      fetch_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (push && (fetch_cnt != 16'hFFFF)) fetch_cnt <= fetch_cnt + 16'd1;
      if (ir_valid && !ir_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  inst_fetch_queue_chk #(.DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .sys_rst (sys_rst),
    .push    (push),
    .count   (count)
  );

endmodule

// Simulation-only checker: a push must never land on a full queue.
module inst_fetch_queue_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   sys_rst,
  input logic                   push,
  input logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_no_overflow: assert property (@(posedge clk) disable iff (!sys_rst)
    !(push && (count == CW'(DEPTH))))
    else $error("fetch queue overflow");

endmodule
